// File: rtl/clb_cfg_pkg.sv
// Shared types and helpers for the CLB configuration loader.
// Holds the loader FSM state encoding and the chain-length helper used to
// size the scan chain from the CLB geometry.
package clb_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_DONE     = 3'd4
    } cfg_state_t;

    // Scan bits for one CLB: mode flop + select fields + LUT SRAM.
    // ble_n does not change the per-tile count today; it is kept in the
    // signature (and referenced) so multi-BLE tiles can extend it later.
    function automatic int clb_chain_len(input int in_w, input int ble_n, input int sel_w);
        return 1 + sel_w * in_w + (2 ** in_w) + (ble_n * 0);
    endfunction

endpackage

// File: rtl/clb_cfg_loader_phase_timer.sv
// Scan clock phase timer: counts DIV clk cycles per scan_clk half-period.
// Latency: ph_end is combinational off the count; lvl toggles on the ph_end edge.
// Backpressure: none; dropping run parks the timer with scan_clk low.
// Ports: clk/rst_n, run (shifting active), ph_end (last cycle of a phase),
//        lvl (scan_clk level, low in the first half of each bit).
module clb_scan_phase_timer #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic ph_end,
    output logic lvl
);

    localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PH_W-1:0] ph_cnt;

    assign ph_end = run && (ph_cnt == PH_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_cnt <= '0;
            lvl    <= 1'b0;
        end else if (!run) begin
            ph_cnt <= '0;
            lvl    <= 1'b0;
        end else if (ph_end) begin
            ph_cnt <= '0;
            lvl    <= ~lvl;
        end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
        end
    end

endmodule

// File: rtl/clb_cfg_loader.sv
// Serialises host config words into a CLB scan chain and returns displaced bits.
// Latency: done at 1 + ceil(CHAIN_LEN/WORD_W) + 2*DIV*CHAIN_LEN cycles after start.
// Backpressure: cfg_ready only in FETCH; stalls hold scan_clk low; rb has none.
// Ports: start/busy/done control; cfg_data/cfg_valid/cfg_ready host stream;
//        scan_clk/scan_en/scan_data/scan_ret chain side; rb_data/rb_valid readback.
module clb_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = clb_chain_len(4, 1, 3),
    parameter int WORD_W    = 8,
    parameter int DIV       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              scan_clk,
    output logic              scan_en,
    output logic              scan_data,
    input  logic              scan_ret,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = $clog2(WORD_W + 1);

    cfg_state_t        state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WB_W-1:0]   wbit_cnt;
    logic [WORD_W-1:0] sh_buf;
    logic [WORD_W-1:0] rb_buf;

    logic              ph_end;
    logic              run;
    logic [BIT_W-1:0]  bit_nxt;
    logic [WB_W-1:0]   wb_nxt;
    logic [WORD_W-1:0] cap_word;
    logic [WORD_W-1:0] sh_nxt;
    logic              rb_last;

    assign run = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);

    clb_scan_phase_timer #(.DIV(DIV)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .ph_end (ph_end),
        .lvl    (scan_clk)
    );

    always_comb begin
        bit_nxt  = bit_cnt + BIT_W'(1);
        wb_nxt   = wbit_cnt + WB_W'(1);
        sh_nxt   = sh_buf >> 1;
        // rb_buf is cleared after every emitted word, so untouched upper
        // bits of a partial final word read back as 0.
        cap_word = rb_buf | (WORD_W'(scan_ret) << wbit_cnt);
        rb_last  = (wbit_cnt == WB_W'(WORD_W - 1)) || (bit_cnt == BIT_W'(CHAIN_LEN - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            wbit_cnt  <= '0;
            sh_buf    <= '0;
            rb_buf    <= '0;
            cfg_ready <= 1'b0;
            scan_en   <= 1'b0;
            scan_data <= 1'b0;
            rb_data   <= '0;
            rb_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_FETCH;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // scan_en is left as-is while stalled so the chain
                    // sees no spurious enable edge between words.
                    if (cfg_valid && cfg_ready) begin
                        sh_buf    <= cfg_data;
                        scan_data <= cfg_data[0];
                        scan_en   <= 1'b1;
                        cfg_ready <= 1'b0;
                        state     <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    // Capture at the end of the low phase: scan_ret still
                    // holds the far-end bit that the coming rise displaces.
                    if (ph_end) begin
                        if (rb_last) begin
                            rb_data  <= cap_word;
                            rb_valid <= 1'b1;
                            rb_buf   <= '0;
                        end else begin
                            rb_buf <= cap_word;
                        end
                        state <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (ph_end) begin
                        bit_cnt <= bit_nxt;
                        if (bit_nxt == BIT_W'(CHAIN_LEN)) begin
                            wbit_cnt <= wb_nxt;
                            scan_en  <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end else if (wb_nxt == WB_W'(WORD_W)) begin
                            wbit_cnt  <= '0;
                            cfg_ready <= 1'b1;
                            state     <= ST_FETCH;
                        end else begin
                            wbit_cnt  <= wb_nxt;
                            sh_buf    <= sh_nxt;
                            scan_data <= sh_nxt[0];
                            state     <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_DONE: begin
                    bit_cnt   <= '0;
                    wbit_cnt  <= '0;
                    scan_data <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
module tb_clb_cfg_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic       scan_clk;
    logic       scan_en;
    logic       scan_data;
    logic       scan_ret;
    logic [7:0] rb_data;
    logic       rb_valid;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;

    // Chain model: 29-bit shift register, scan_in at bit 0, scan_out at bit 28.
    logic [28:0] chain = '0;
    int          rise_cnt = 0;
    assign scan_ret = chain[28];

    always @(posedge scan_clk) begin
        chain    <= {chain[27:0], scan_data};
        rise_cnt <= rise_cnt + 1;
    end

    always #5 clk = ~clk;

    clb_cfg_loader #(.CHAIN_LEN(29), .WORD_W(8), .DIV(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .scan_clk  (scan_clk),
        .scan_en   (scan_en),
        .scan_data (scan_data),
        .scan_ret  (scan_ret),
        .rb_data   (rb_data),
        .rb_valid  (rb_valid),
        .busy      (busy),
        .done      (done)
    );

    logic [7:0] rb_seen [8];
    int         done_cyc;
    int         done_n;
    int         rb_n;

    // Bit i of the load (LSB of word 0 first) ends up at chain[28-i].
    function automatic logic [28:0] exp_chain(input logic [7:0] w0, input logic [7:0] w1,
                                              input logic [7:0] w2, input logic [7:0] w3);
        logic [31:0] s;
        logic [28:0] c;
        s = {w3, w2, w1, w0};
        c = '0;
        for (int i = 0; i < 29; i++) c[28 - i] = s[i];
        return c;
    endfunction

    task automatic run_load(input string tag,
                            input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3,
                            input int gap, input int dup_at, input int exp_cyc,
                            input bit chk_rb,
                            input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3);
        logic [7:0]  words [4];
        logic [7:0]  exp_rb [4];
        logic [28:0] snap;
        int          rise0;
        int          busy_err;
        int          gap_err;
        int          extra_done;
        int          busy_after;
        bit          got;
        int          cyc;
        words  = '{w0, w1, w2, w3};
        exp_rb = '{r0, r1, r2, r3};
        done_cyc = 0; done_n = 0; rb_n = 0;
        busy_err = 0; gap_err = 0; extra_done = 0; busy_after = 0;
        rise0 = rise_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        fork
            begin
                for (int w = 0; w < 4; w++) begin
                    cfg_data  = words[w];
                    cfg_valid = 1'b1;
                    got = 1'b0;
                    for (int t = 0; t < 200 && !got; t++) begin
                        @(negedge clk);
                        if (cfg_ready) begin
                            if (w == 1 && gap > 0) begin
                                cfg_valid = 1'b0;
                                snap = chain;
                                for (int g = 0; g < gap; g++) begin
                                    if (scan_clk !== 1'b0 || scan_en !== 1'b1) gap_err++;
                                    @(negedge clk);
                                end
                                total++;
                                if (gap_err != 0 || chain !== snap) begin
                                    bad++;
                                    $display("FAIL %s gap_hold: errs=%0d chain=%h required chain=%h",
                                             tag, gap_err, chain, snap);
                                end
                                cfg_valid = 1'b1;
                            end
                            @(posedge clk);
                            #1 got = 1'b1;
                        end
                    end
                    if (!got) begin
                        total++; bad++;
                        $display("FAIL %s feed_timeout: word %0d never accepted", tag, w);
                    end
                end
                cfg_valid = 1'b0;
            end
            begin
                cyc = 0;
                while (cyc < 400 && done_n == 0) begin
                    @(negedge clk);
                    cyc++;
                    if (dup_at > 0) start = (cyc == dup_at);
                    if (busy !== 1'b1) busy_err++;
                    if (rb_valid === 1'b1) begin
                        if (rb_n < 8) rb_seen[rb_n] = rb_data;
                        rb_n++;
                    end
                    if (done === 1'b1) begin
                        done_n++;
                        done_cyc = cyc;
                    end
                end
                start = 1'b0;
            end
        join
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
            if (busy !== 1'b0) busy_after++;
        end

        total++;
        if (done_cyc != exp_cyc) begin
            bad++;
            $display("FAIL %s done_cycle: got %0d required %0d", tag, done_cyc, exp_cyc);
        end
        total++;
        if (rise_cnt - rise0 != 29) begin
            bad++;
            $display("FAIL %s scan_clk_rises: got %0d required 29", tag, rise_cnt - rise0);
        end
        total++;
        if (chain !== exp_chain(w0, w1, w2, w3)) begin
            bad++;
            $display("FAIL %s chain: got %h required %h", tag, chain, exp_chain(w0, w1, w2, w3));
        end
        total++;
        if (busy_err != 0 || busy_after != 0 || extra_done != 0) begin
            bad++;
            $display("FAIL %s busy_done: busy_low=%0d busy_after=%0d extra_done=%0d required 0/0/0",
                     tag, busy_err, busy_after, extra_done);
        end
        if (chk_rb) begin
            total++;
            if (rb_n != 4) begin
                bad++;
                $display("FAIL %s rb_count: got %0d required 4", tag, rb_n);
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (rb_seen[i] !== exp_rb[i]) begin
                    bad++;
                    $display("FAIL %s rb_word%0d: got %h required %h", tag, i, rb_seen[i], exp_rb[i]);
                end
            end
        end
    endtask

    task automatic test_reset;
        #3;
        total++;
        if ({scan_clk, scan_en, scan_data, cfg_ready, rb_valid, busy, done} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {scan_clk, scan_en, scan_data, cfg_ready, rb_valid, busy, done});
        end
        total++;
        if (rb_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_rb_data: got %h required 00", rb_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b cfg_ready=%b required 0/0", busy, cfg_ready);
        end
    endtask

    task automatic test_ones;
        run_load("ones", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, 121, 1'b1,
                 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_readback;
        run_load("zeros", 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 121, 1'b1,
                 8'hFF, 8'hFF, 8'hFF, 8'h1F);
    endtask

    task automatic test_pattern;
        run_load("pattern", 8'hA5, 8'h3C, 8'h0F, 8'h12, 0, 0, 121, 1'b1,
                 8'h00, 8'h00, 8'h00, 8'h00);
        total++;
        if (chain[28] !== 1'b1) begin
            bad++;
            $display("FAIL pattern_far_end: got %b required 1", chain[28]);
        end
    endtask

    task automatic test_stall;
        run_load("stall", 8'h81, 8'h7E, 8'h55, 8'h0B, 10, 0, 131, 1'b1,
                 8'hA5, 8'h3C, 8'h0F, 8'h12);
    endtask

    task automatic test_start_while_busy;
        run_load("dup_start", 8'hF0, 8'h0F, 8'hAA, 8'hFF, 0, 60, 121, 1'b1,
                 8'h81, 8'h7E, 8'h55, 8'h0B);
    endtask

    task automatic test_reset_mid_load;
        bit got;
        @(negedge clk);
        start = 1'b1; cfg_data = 8'hFF; cfg_valid = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (scan_clk === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL midload_reach_hi: scan_clk never rose");
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({scan_clk, scan_en, scan_data, cfg_ready, rb_valid, busy, done} !== 7'b0 ||
            rb_data !== 8'h00) begin
            bad++;
            $display("FAIL midload_reset: ctrl=%b rb=%h required 0000000/00",
                     {scan_clk, scan_en, scan_data, cfg_ready, rb_valid, busy, done}, rb_data);
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_load("after_reset", 8'h5A, 8'h96, 8'h33, 8'h1C, 0, 0, 121, 1'b0,
                 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    initial begin
        test_reset();
        test_ones();
        test_readback();
        test_pattern();
        test_stall();
        test_start_while_busy();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
